// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and defaults for the bit-serial add/subtract sequencer.
//   - state_t       : sequencer state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/result width
// ----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell, purely combinational.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     sum   : a ^ b ^ cin
//     cout  : majority(a, b, cin)
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract sequencer built around one full_adder cell.
//   Operands are captured on a start/ready handshake and fed LSB first, one
//   bit pair per clock, with a registered carry between bits.
//
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     start     : request, accepted when start & ready at a clock edge
//     ready     : high in IDLE only
//     a, b      : WIDTH-bit operands, captured on accept
//     cin       : carry-in for add (ignored for subtract), captured on accept
//     sub       : 0 = a + b + cin, 1 = a - b, captured on accept
//     busy      : high in RUN and DONE
//     result    : sum/difference, updated at the RUN->DONE edge and held
//     cout      : MSB carry-out (for subtract, 1 = no borrow)
//     overflow  : two's-complement overflow of the operation
//     done      : one-cycle pulse, outputs final
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; ready=1; last result held on outputs
//   RUN   | one bit pair per clock through the cell, cnt = bit index
//   DONE  | done pulse for one cycle, then back to IDLE
// ----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only WIDTH-1 partial bits are kept; the final sum bit goes straight into
  // result on the last cycle, so no storage bit is ever left unused.
  logic [WIDTH-2:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  full_adder u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters from the MSB side; after WIDTH shifts bit 0 of the
  // operation has reached bit 0 of the word.
  assign res_next = {fa_sum, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b and force the initial carry.
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
            res_sh <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          carry  <= fa_cout;
          if (cnt == LAST) begin
            result   <= res_next;
            cout     <= fa_cout;
            // carry holds the carry into the MSB at this point.
            overflow <= carry ^ fa_cout;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             done;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ready    (ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    int               acc;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_cout"}, 32'(cout), 32'(e.co));
        chk({e.name, "_overflow"}, 32'(overflow), 32'(e.ov));
        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(WIDTH));
      end
    end
  end

  // Waits for ready, presents the operands with start=1 and returns after the
  // accept edge. start is left high; the caller decides when to drop it.
  task automatic issue(input string nm, input logic [7:0] ia, input logic [7:0] ib,
                       input logic icin, input logic isub,
                       input logic [7:0] eres, input logic eco, input logic eov,
                       input bit push, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    a = ia;
    b = ib;
    cin = icin;
    sub = isub;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{eres, eco, eov, acc, nm});
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !ready) chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_prev;

    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    #11 rst_n = 1'b1;

    // 0x5A + 0x33 with ready-low window check
    issue("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1, acc);
    start = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      @(negedge clk);
      chk("ready_low_window", 32'(ready), 32'd0);
      chk("busy_high_window", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("ready_back", 32'(ready), 32'd1);
    wait_idle("add_5a_33");

    issue("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    start = 1'b0;
    wait_idle("add_ff_01");

    issue("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, acc);
    start = 1'b0;
    wait_idle("add_7f_00_c");

    issue("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, acc);
    start = 1'b0;
    wait_idle("sub_10_20");

    issue("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, acc);
    start = 1'b0;
    wait_idle("sub_80_01");

    issue("sub_55_55", 8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    start = 1'b0;
    wait_idle("sub_55_55");

    // start and operand changes during RUN must not disturb the running op
    issue("add_12_34_c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b1, acc);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      a = 8'hFF;
      b = 8'hFF;
      cin = 1'b0;
      sub = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("add_12_34_c");

    // start held high: accepts exactly WIDTH+2 cycles apart
    issue("b2b_0", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, acc_prev);
    for (int i = 1; i < 3; i++) begin
      issue("b2b_n", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, acc);
      chk("b2b_spacing", 32'(acc - acc_prev), 32'(WIDTH + 2));
      acc_prev = acc;
    end
    start = 1'b0;
    wait_idle("b2b");

    // async reset in the middle of RUN abandons the operation
    issue("rst_mid", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    issue("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, acc);
    start = 1'b0;
    wait_idle("add_01_01");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl
